// File: rtl/uart_alu_frame_bridge_pkg.sv
// Shared types and constants for the UART ALU frame bridge: FSM states,
// opcode values and the helpers that size byte and timeout counters.
package uart_alu_frame_bridge_pkg;

  typedef enum logic [2:0] {
    ST_RX_A    = 3'd0,
    ST_RX_B    = 3'd1,
    ST_RX_OP   = 3'd2,
    ST_CALC    = 3'd3,
    ST_TX_SEND = 3'd4,
    ST_TX_WAIT = 3'd5
  } state_t;

  localparam int OP_SRL = 'h02;
  localparam int OP_SRA = 'h03;
  localparam int OP_ADD = 'h20;
  localparam int OP_SUB = 'h22;
  localparam int OP_AND = 'h24;
  localparam int OP_OR  = 'h25;
  localparam int OP_XOR = 'h26;
  localparam int OP_NOR = 'h27;

  function automatic int nbytes(input int dw);
    return dw / 8;
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_alu_frame_bridge_if.sv
// Byte-level handshake between the UART rx/tx pair and the frame bridge.
interface uart_alu_frame_bridge_if;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       frame_error;
  logic       rx_overrun;

  modport master (
    output rx_done_tick, rx_data, tx_done_tick,
    input  tx_start, tx_data, busy, frame_error, rx_overrun
  );

  modport slave (
    input  rx_done_tick, rx_data, tx_done_tick,
    output tx_start, tx_data, busy, frame_error, rx_overrun
  );
endinterface

// File: rtl/uart_alu_frame_bridge_alu_core.sv
// Combinational ALU: add/sub/logic ops and logical/arithmetic right shifts.
module alu_core
  import uart_alu_frame_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [OP_WIDTH-1:0]   op_i,
  output logic [DATA_WIDTH-1:0] y_o
);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SH_LIMIT = DATA_WIDTH'(DATA_WIDTH);

  logic big_shift;
  assign big_shift = (b_i >= SH_LIMIT);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_WIDTH'(OP_ADD): y_o = a_i + b_i;
      OP_WIDTH'(OP_SUB): y_o = a_i - b_i;
      OP_WIDTH'(OP_AND): y_o = a_i & b_i;
      OP_WIDTH'(OP_OR):  y_o = a_i | b_i;
      OP_WIDTH'(OP_XOR): y_o = a_i ^ b_i;
      OP_WIDTH'(OP_NOR): y_o = ~(a_i | b_i);
      OP_WIDTH'(OP_SRL): y_o = big_shift ? '0 : (a_i >> b_i[SW-1:0]);
      OP_WIDTH'(OP_SRA): y_o = big_shift ? {DATA_WIDTH{a_i[DATA_WIDTH-1]}}
                                         : $unsigned($signed(a_i) >>> b_i[SW-1:0]);
      default:           y_o = '0;
    endcase
  end
endmodule

// File: rtl/uart_alu_frame_bridge.sv
// Collects A, B and opcode bytes from the UART, runs them through alu_core and
// streams the result back little-endian, paced by tx_done_tick.
module uart_alu_frame_bridge
  import uart_alu_frame_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  uart_alu_frame_bridge_if.slave  bus
);
  localparam int NBYTES = nbytes(DATA_WIDTH);
  localparam int CW     = cnt_width(NBYTES);
  localparam int TW     = cnt_width(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST    = CW'(NBYTES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, alu_y;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [TW-1:0]         to_q, to_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d, busy_q, busy_d;
  logic                  ferr_q, ferr_d, ovr_q, ovr_d;
  logic                  rx_phase, accept, to_run, expire, last_byte;

  alu_core #(.DATA_WIDTH(DATA_WIDTH), .OP_WIDTH(OP_WIDTH)) u_alu (
    .a_i(a_q), .b_i(b_q), .op_i(op_q), .y_o(alu_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RX_A;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      to_q       <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      to_q       <= to_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  // A byte arriving on the expiry cycle is accepted, so expire excludes it.
  always_comb begin
    rx_phase  = (state_q == ST_RX_A) || (state_q == ST_RX_B) || (state_q == ST_RX_OP);
    accept    = rx_phase && bus.rx_done_tick;
    last_byte = (cnt_q == LAST);
    to_run    = (state_q == ST_RX_B) || (state_q == ST_RX_OP) ||
                ((state_q == ST_RX_A) && (cnt_q != '0));
    expire    = (TIMEOUT_CYCLES != 0) && to_run && !bus.rx_done_tick && (to_q == TO_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RX_A:    if (accept && last_byte) state_d = ST_RX_B;
                  else if (expire)         state_d = ST_RX_A;
      ST_RX_B:    if (accept && last_byte) state_d = ST_RX_OP;
                  else if (expire)         state_d = ST_RX_A;
      ST_RX_OP:   if (accept)              state_d = ST_CALC;
                  else if (expire)         state_d = ST_RX_A;
      ST_CALC:    state_d = ST_TX_SEND;
      ST_TX_SEND: state_d = ST_TX_WAIT;
      ST_TX_WAIT: if (bus.tx_done_tick)    state_d = last_byte ? ST_RX_A : ST_TX_SEND;
      default:    state_d = ST_RX_A;
    endcase
  end

  // Reply bytes are loaded on entry to TX_SEND so tx_start lines up with that state.
  always_comb begin
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    to_d       = to_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    ferr_d     = 1'b0;
    ovr_d      = bus.rx_done_tick && !rx_phase;

    if (accept)
      to_d = '0;
    else if (to_run && (TIMEOUT_CYCLES != 0))
      to_d = to_q + 1'b1;

    if (accept) begin
      busy_d = 1'b1;
      case (state_q)
        ST_RX_A: a_d[8*int'(cnt_q) +: 8] = bus.rx_data;
        ST_RX_B: b_d[8*int'(cnt_q) +: 8] = bus.rx_data;
        default: op_d = bus.rx_data[OP_WIDTH-1:0];
      endcase
      if (state_q != ST_RX_OP)
        cnt_d = last_byte ? '0 : cnt_q + 1'b1;
    end else if (expire) begin
      a_d    = '0;
      b_d    = '0;
      op_d   = '0;
      cnt_d  = '0;
      to_d   = '0;
      busy_d = 1'b0;
      ferr_d = 1'b1;
    end

    if (state_q == ST_CALC) begin
      res_d      = alu_y;
      tx_start_d = 1'b1;
      tx_data_d  = alu_y[7:0];
    end else if ((state_q == ST_TX_WAIT) && bus.tx_done_tick) begin
      if (last_byte) begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d      = cnt_q + 1'b1;
        tx_start_d = 1'b1;
        tx_data_d  = res_q[8*(int'(cnt_q)+1) +: 8];
      end
    end
  end

  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = busy_q;
  assign bus.frame_error = ferr_q;
  assign bus.rx_overrun  = ovr_q;
endmodule

// File: tb/tb_uart_alu_frame_bridge.sv
// Bench for the 16-bit bridge: vector table, random frames against an
// arithmetic reference, and timeout / overrun / reset sequences.
module tb_uart_alu_frame_bridge;
  localparam int DW = 16;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   ferr_seen = 0;

  uart_alu_frame_bridge_if bus ();

  uart_alu_frame_bridge #(.DATA_WIDTH(DW), .OP_WIDTH(6), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_error) ferr_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  opb;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [7:0] opb);
    int op = int'(opb) % 64;
    int ia = int'(a);
    int ib = int'(b);
    int sa;
    case (op)
      'h20: return 16'((ia + ib) % 65536);
      'h22: return 16'((ia - ib + 65536) % 65536);
      'h24: return a & b;
      'h25: return a | b;
      'h26: return a ^ b;
      'h27: return ~(a | b);
      'h02: return (ib >= 16) ? 16'h0000 : 16'(ia / (1 << ib));
      'h03: begin
        sa = (ia >= 32768) ? ia - 65536 : ia;
        if (ib >= 16) return (sa < 0) ? 16'hFFFF : 16'h0000;
        return 16'(sa >>> ib);
      end
      default: return 16'h0000;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] v);
    bus.rx_data      = v;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  // mode 0: normal; 1: inject an rx byte during TX_WAIT; 2: reset during TX_WAIT.
  task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] opb,
                           input logic [15:0] exp, input int mode);
    logic [7:0] frame [5];
    logic [7:0] got [2];
    int lat, stray;
    frame = '{a[7:0], a[15:8], b[7:0], b[15:8], opb};
    got   = '{8'h00, 8'h00};
    for (int i = 0; i < 5; i++) begin
      send_byte(frame[i]);
      if (i < 4) repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    check("busy_after_op", bus.busy, 1);
    for (int k = 0; k < 2; k++) begin
      lat = 0;
      while (!bus.tx_start && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("tx_start_seen", bus.tx_start, 1);
      check("tx_latency", lat, (k == 0) ? 1 : 0);
      check("tx_byte", bus.tx_data, exp[8*k +: 8]);
      got[k] = bus.tx_data;
      stray = 0;
      if (mode == 2) begin
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_busy", bus.busy, 0);
        reset = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (bus.tx_start) stray++;
        end
        check("no_tx_after_reset", stray, 0);
        $display("frame a=%04h b=%04h op=%02h aborted by reset after byte0=%02h", a, b, opb, got[0]);
        return;
      end
      if (mode == 1 && k == 0) begin
        @(negedge clk);
        send_byte(8'hAA);
        check("rx_overrun", bus.rx_overrun, 1);
        if (bus.tx_start) stray++;
      end
      repeat ($urandom_range(1, 6)) begin
        @(negedge clk);
        if (bus.tx_start) stray++;
      end
      check("no_early_tx_start", stray, 0);
      bus.tx_done_tick = 1'b1;
      @(negedge clk);
      bus.tx_done_tick = 1'b0;
    end
    check("busy_after_reply", bus.busy, 0);
    $display("frame a=%04h b=%04h op=%02h reply=%02h %02h expect=%04h", a, b, opb,
             got[0], got[1], exp);
  endtask

  initial begin
    int ops [10];
    int pulses, at;
    logic [15:0] ra, rb;
    logic [7:0]  rop;

    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.tx_done_tick = 1'b0;
    reset            = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_start", bus.tx_start, 0);
    check("reset_tx_data", bus.tx_data, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_frame_error", bus.frame_error, 0);
    check("reset_rx_overrun", bus.rx_overrun, 0);
    reset = 1'b0;
    @(negedge clk);

    vecs[0]  = '{16'h1234, 16'h0101, 8'h20, 16'h1335};
    vecs[1]  = '{16'h0000, 16'h0001, 8'h22, 16'hFFFF};
    vecs[2]  = '{16'h8000, 16'h0004, 8'h03, 16'hF800};
    vecs[3]  = '{16'hFFFF, 16'h0010, 8'h02, 16'h0000};
    vecs[4]  = '{16'h8000, 16'h0010, 8'h03, 16'hFFFF};
    vecs[5]  = '{16'h7FFF, 16'h0020, 8'h03, 16'h0000};
    vecs[6]  = '{16'hF0F0, 16'h0FF0, 8'h25, 16'hFFF0};
    vecs[7]  = '{16'hF0F0, 16'h0FF0, 8'h26, 16'hFF00};
    vecs[8]  = '{16'hF0F0, 16'h0FF0, 8'h27, 16'h000F};
    vecs[9]  = '{16'h00FF, 16'h0001, 8'hE0, 16'h0100};
    vecs[10] = '{16'h1234, 16'h5678, 8'h3F, 16'h0000};
    vecs[11] = '{16'h8000, 16'h000F, 8'h02, 16'h0001};
    vecs[12] = '{16'h0005, 16'h0003, 8'h24, 16'h0001};
    for (int i = 0; i < 13; i++)
      run_frame(vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].exp, 0);

    ops = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h02, 'h03, 'h3F, 'h21};
    for (int i = 0; i < 20; i++) begin
      rop = 8'(ops[$urandom_range(0, 9)]) | 8'($urandom_range(0, 3) << 6);
      ra  = 16'($urandom);
      rb  = (rop[5:0] == 6'h02 || rop[5:0] == 6'h03) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      run_frame(ra, rb, rop, ref_alu(ra, rb, rop), 0);
    end

    // Lone byte then silence: exactly one discard after TO idle cycles.
    send_byte(8'h11);
    pulses = 0;
    at = -1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (bus.frame_error) begin
        pulses++;
        if (at < 0) at = i;
      end
    end
    check("timeout_pulses", pulses, 1);
    check("timeout_cycle", at, TO);
    check("timeout_busy", bus.busy, 0);
    $display("timeout: pulses=%0d at_cycle=%0d", pulses, at);
    run_frame(16'h0001, 16'h0002, 8'h20, 16'h0003, 0);

    run_frame(16'h1234, 16'h0101, 8'h20, 16'h1335, 1);
    run_frame(16'h0002, 16'h0003, 8'h20, 16'h0005, 0);

    bus.tx_done_tick = 1'b1;
    @(negedge clk);
    bus.tx_done_tick = 1'b0;
    @(negedge clk);
    check("idle_done_tx_start", bus.tx_start, 0);
    check("idle_done_busy", bus.busy, 0);
    $display("stray tx_done_tick while idle applied");

    run_frame(16'h1234, 16'h0101, 8'h20, 16'h1335, 2);
    run_frame(16'h0005, 16'h0003, 8'h24, 16'h0001, 0);

    check("frame_error_total", ferr_seen, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_alu_frame_bridge.md
Name: uart_alu_frame_bridge

Overview:
Byte-stream front end between the UART receiver/transmitter pair and a parametrised ALU core; successor of the fixed 8-bit A/B/OP/result bridge. Collects a multi-byte frame (operand A, operand B, opcode), computes the result in a parametrised ALU sub-module, and returns it as a multi-byte reply. Transmission is paced by tx_done_tick. Adds an inter-byte timeout with frame discard, plus error/overrun flags.

Parameters:
DATA_WIDTH, 8, operand/result width in bits; multiple of 8, >= 8; NBYTES = DATA_WIDTH/8
OP_WIDTH, 6, opcode bits taken from the low bits of the opcode byte
TIMEOUT_CYCLES, 100000, max clk cycles between bytes inside a frame; 0 disables timeout

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
rx_done_tick  in  1  one-cycle pulse: rx_data valid
rx_data  in  8  received byte
tx_done_tick  in  1  one-cycle pulse: transmitter finished current byte
tx_start  out  1  one-cycle pulse: load tx_data into transmitter
tx_data  out  8  byte to transmit, held stable from tx_start until next tx_start
busy  out  1  high from first byte of a frame until last reply byte's tx_done_tick
frame_error  out  1  one-cycle pulse: frame discarded by timeout
rx_overrun  out  1  one-cycle pulse: rx_done_tick arrived during CALC/TX and was dropped

Behaviour:
- Reset (async): state RX_A, byte counter 0, operand/op/result regs 0, timeout counter 0; tx_start 0, tx_data 0x00, busy 0, frame_error 0, rx_overrun 0.
- Byte order little-endian: first byte received/sent is bits [7:0].
- States: RX_A, RX_B, RX_OP, CALC, TX_SEND, TX_WAIT.
- RX_A: each rx_done_tick writes rx_data into A byte[cnt], cnt++; after byte NBYTES-1, cnt <= 0, go RX_B. busy rises the cycle after the first A byte.
- RX_B: same for B; after last byte go RX_OP.
- RX_OP: rx_done_tick latches rx_data[OP_WIDTH-1:0] into op, go CALC.
- CALC: one cycle; result register <= ALU(A,B,op); go TX_SEND.
- TX_SEND: tx_data <= result byte[cnt], tx_start pulsed 1 cycle; go TX_WAIT.
- TX_WAIT: on tx_done_tick: if cnt == NBYTES-1 then cnt <= 0, go RX_A, busy <= 0; else cnt++, go TX_SEND.
- Latency: opcode byte accepted at edge N -> result registered at N+1 -> tx_start high during cycle after N+1, with tx_data = result[7:0].
- Timeout: counter cleared on every accepted rx_done_tick; increments while state is RX_B/RX_OP, or RX_A with cnt != 0. When it reaches TIMEOUT_CYCLES: frame_error pulse, A/B/op cleared, cnt 0, state RX_A, busy 0. A tick and the expiry on the same cycle: tick wins (byte accepted, counter cleared). Counter does not run in CALC/TX states.
- rx_done_tick in CALC/TX_SEND/TX_WAIT: byte discarded, rx_overrun pulse; no state change.
- tx_done_tick outside TX_WAIT: ignored.
- ALU (opcode, result truncated to DATA_WIDTH): 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x02 SRL A by B, 0x03 SRA A by B; shift amount >= DATA_WIDTH gives 0 (SRL) or all sign bits (SRA); any other opcode gives 0. Purely combinational; no flags.
- Reset mid-frame or mid-reply: immediate abort, no further tx_start; next frame starts clean.

Decomposition:
- Shared package: opcode constants (OP_ADD..OP_SRA), state encoding localparams, NBYTES derivation, clog2-based counter widths.
- One sub-module: alu_core #(DATA_WIDTH, OP_WIDTH), combinational, instantiated once. Bridge FSM, counters and registers remain in uart_alu_frame_bridge.

Test Plan:
- DATA_WIDTH=16, send 34 12 01 01 20 -> tx bytes 35 then 13, each tx_start only after previous tx_done_tick; busy low after final tx_done_tick.
- DATA_WIDTH=16 SUB wrap: 00 00 01 00 22 -> reply FF FF.
- DATA_WIDTH=16 SRA: 00 80 04 00 03 -> reply 00 F8. SRL with B=0x0010 -> 00 00.
- TIMEOUT_CYCLES=50: send one byte, idle 50 cycles -> single frame_error pulse, busy 0; then 01 00 02 00 20 -> reply 03 00.
- Inject rx_done_tick (0xAA) during TX_WAIT -> rx_overrun pulse, reply bytes unchanged, next frame parses from A byte 0.
- Assert reset during TX_WAIT after first reply byte -> tx_start stays 0, outputs return to reset values; following frame 05 00 03 00 24 -> reply 01 00.
